// File: rtl/uart_word_receiver_if.sv
// uart_word_receiver_if
// Serial input and byte/word result bus of uart_word_receiver.
//   RxD                  serial line into the receiver (idles high)
//   RxD_byte_data        last good byte
//   RxD_byte_ready       1-cycle strobe, RxD_byte_data valid
//   RxD_word_data        last complete word (8*WORD_BYTES bits)
//   RxD_word_data_ready  1-cycle strobe, RxD_word_data updated
//   frame_error          1-cycle strobe, stop bit sampled low
//   word_timeout         1-cycle strobe, partial word dropped on idle
//   parity_error         1-cycle strobe, only with UART_RX_PARITY_EN defined
// modports: master = line driver / result consumer, slave = receiver.
interface uart_word_receiver_if #(
  parameter int unsigned WORD_BYTES = 4
);
  logic                    RxD;
  logic [7:0]              RxD_byte_data;
  logic                    RxD_byte_ready;
  logic [8*WORD_BYTES-1:0] RxD_word_data;
  logic                    RxD_word_data_ready;
  logic                    frame_error;
  logic                    word_timeout;
`ifdef UART_RX_PARITY_EN
  logic                    parity_error;
`endif

  modport master (
`ifdef UART_RX_PARITY_EN
    input  parity_error,
`endif
    output RxD,
    input  RxD_byte_data, RxD_byte_ready, RxD_word_data, RxD_word_data_ready,
           frame_error, word_timeout
  );

  modport slave (
`ifdef UART_RX_PARITY_EN
    output parity_error,
`endif
    input  RxD,
    output RxD_byte_data, RxD_byte_ready, RxD_word_data, RxD_word_data_ready,
           frame_error, word_timeout
  );
endinterface

// File: rtl/uart_word_receiver.sv
// uart_word_receiver
// Oversampling UART receiver (8N1, LSB first) that packs WORD_BYTES bytes
// into one word for the processor loader. Rejects false starts, reports
// framing errors and discards a partial word after an idle timeout.
// Optional even-parity frames (8E1) when UART_RX_PARITY_EN is defined.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  uart_word_receiver_if.slave: RxD in; byte/word results, strobes out
module uart_word_receiver #(
  parameter int unsigned CLKS_PER_BIT         = 64,
  parameter int unsigned WORD_BYTES           = 4,
  parameter int unsigned BYTE_ORDER_MSB_FIRST = 0,
  parameter int unsigned IDLE_TIMEOUT_BITS    = 16
) (
  input  logic clk,
  input  logic rst,
  uart_word_receiver_if.slave bus
);
  localparam int unsigned WORD_W    = 8 * WORD_BYTES;
  localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned TO_CYCLES = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam bit          TO_EN     = (IDLE_TIMEOUT_BITS != 0);

  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } stateT;

  stateT              state;
  logic               rxMeta;
  logic               rxS;
  logic [BAUD_W-1:0]  baudCnt;
  logic [2:0]         bitIdx;
  logic [7:0]         shiftReg;
  logic [IDX_W-1:0]   byteIdx;
  logic [TO_W-1:0]    toCnt;
  logic [WORD_W-1:0]  assembly;
  logic [7:0]         byteData;
  logic               byteReady;
  logic [WORD_W-1:0]  wordData;
  logic               wordReady;
  logic               frameErr;
  logic               wordTimeout;
`ifdef UART_RX_PARITY_EN
  logic               parityBit;
  logic               parityErr;
`endif

  logic [IDX_W-1:0]   byteSlot;
  logic [WORD_W-1:0]  slotMask;
  logic [WORD_W-1:0]  assemblyNext;

  // Assembly register with the just-received byte dropped into its slot
  always_comb begin
    byteSlot     = (BYTE_ORDER_MSB_FIRST != 0) ? (LAST_IDX - byteIdx) : byteIdx;
    slotMask     = WORD_W'(8'hFF) << {byteSlot, 3'b000};
    assemblyNext = (assembly & ~slotMask) | (WORD_W'(shiftReg) << {byteSlot, 3'b000});
  end

  // Synchroniser, receive FSM, word assembly and idle timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta      <= 1'b1;
      rxS         <= 1'b1;
      state       <= IDLE;
      baudCnt     <= '0;
      bitIdx      <= '0;
      shiftReg    <= '0;
      byteIdx     <= '0;
      toCnt       <= '0;
      assembly    <= '0;
      byteData    <= '0;
      byteReady   <= 1'b0;
      wordData    <= '0;
      wordReady   <= 1'b0;
      frameErr    <= 1'b0;
      wordTimeout <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBit   <= 1'b0;
      parityErr   <= 1'b0;
`endif
    end else begin
      rxMeta      <= bus.RxD;
      rxS         <= rxMeta;
      byteReady   <= 1'b0;
      wordReady   <= 1'b0;
      frameErr    <= 1'b0;
      wordTimeout <= 1'b0;
      toCnt       <= '0;
`ifdef UART_RX_PARITY_EN
      parityErr   <= 1'b0;
`endif

      case (state)
        IDLE: begin
          baudCnt <= '0;
          // Expiry beats a simultaneous start edge: the new byte opens a fresh word
          if (TO_EN && (byteIdx != '0) && (toCnt == TO_LAST)) begin
            wordTimeout <= 1'b1;
            byteIdx     <= '0;
          end else if (TO_EN && (byteIdx != '0) && rxS) begin
            toCnt <= toCnt + TO_W'(1);
          end
          if (!rxS) state <= START;
        end

        START: begin
          if (baudCnt == HALF_BIT) begin
            baudCnt <= '0;
            if (rxS) begin
              state <= IDLE;
            end else begin
              state  <= DATA;
              bitIdx <= '0;
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baudCnt == FULL_BIT) begin
            baudCnt  <= '0;
            shiftReg <= {rxS, shiftReg[7:1]};
            if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baudCnt == FULL_BIT) begin
            baudCnt   <= '0;
            parityBit <= rxS;
            state     <= STOP;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
`endif

        STOP: begin
          if (baudCnt == FULL_BIT) begin
            baudCnt <= '0;
            if (!rxS) begin
              frameErr <= 1'b1;
              byteIdx  <= '0;
              state    <= WAIT_HIGH;
            end
`ifdef UART_RX_PARITY_EN
            else if (parityBit != ^shiftReg) begin
              parityErr <= 1'b1;
              byteIdx   <= '0;
              state     <= IDLE;
            end
`endif
            else begin
              byteData  <= shiftReg;
              byteReady <= 1'b1;
              assembly  <= assemblyNext;
              if (byteIdx == LAST_IDX) begin
                wordData  <= assemblyNext;
                wordReady <= 1'b1;
                byteIdx   <= '0;
              end else begin
                byteIdx <= byteIdx + IDX_W'(1);
              end
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end

        WAIT_HIGH: begin
          if (rxS) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RxD_byte_data       = byteData;
  assign bus.RxD_byte_ready      = byteReady;
  assign bus.RxD_word_data       = wordData;
  assign bus.RxD_word_data_ready = wordReady;
  assign bus.frame_error         = frameErr;
  assign bus.word_timeout        = wordTimeout;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error        = parityErr;
`endif
endmodule

// File: tb/tb_uart_word_receiver.sv
// tb_uart_word_receiver
// Two receivers (LSB-first and MSB-first byte order) share one serial line.
// Directed vector table, hand-written corner sequences and a randomised
// frame stream checked against a frame-level reference model.
module tb_uart_word_receiver;
  localparam int unsigned CPB = 64;
  localparam int unsigned WB  = 4;
  localparam int unsigned TOB = 16;
  localparam int unsigned TO_CYCLES = TOB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxLine = 1'b1;

  uart_word_receiver_if #(.WORD_BYTES(WB)) busA ();
  uart_word_receiver_if #(.WORD_BYTES(WB)) busB ();
  assign busA.RxD = rxLine;
  assign busB.RxD = rxLine;

  uart_word_receiver #(
    .CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .BYTE_ORDER_MSB_FIRST(0), .IDLE_TIMEOUT_BITS(TOB)
  ) dutLsb (.clk(clk), .rst(rst), .bus(busA));

  uart_word_receiver #(
    .CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .BYTE_ORDER_MSB_FIRST(1), .IDLE_TIMEOUT_BITS(TOB)
  ) dutMsb (.clk(clk), .rst(rst), .bus(busB));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed events, collected away from the active edge
  int          cyc = 0;
  logic [7:0]  byteQ[$];
  logic [31:0] wordQA[$];
  logic [31:0] wordQB[$];
  int          ferrA = 0, toA = 0, toB = 0, perrA = 0, stray = 0;
  int          byteCyc = 0, toCycA = 0;
  logic [31:0] prevWordA = '0, prevWordB = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busA.RxD_byte_ready) begin
      byteQ.push_back(busA.RxD_byte_data);
      byteCyc = cyc;
    end
    if (busA.RxD_word_data_ready) begin
      wordQA.push_back(busA.RxD_word_data);
      if (!busA.RxD_byte_ready) stray++;
    end
    if (busB.RxD_word_data_ready) begin
      wordQB.push_back(busB.RxD_word_data);
      if (!busB.RxD_byte_ready) stray++;
    end
    if (!rst && !busA.RxD_word_data_ready && busA.RxD_word_data != prevWordA) stray++;
    if (!rst && !busB.RxD_word_data_ready && busB.RxD_word_data != prevWordB) stray++;
    prevWordA = busA.RxD_word_data;
    prevWordB = busB.RxD_word_data;
    if (busA.frame_error) ferrA++;
    if (busA.word_timeout) begin
      toA++;
      toCycA = cyc;
    end
    if (busB.word_timeout) toB++;
`ifdef UART_RX_PARITY_EN
    if (busA.parity_error) perrA++;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic v);
    rxLine = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, optional even parity, stop, one idle bit
  task automatic sendFrame(input logic [7:0] d, input bit stopOk, input bit parOk);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
`ifdef UART_RX_PARITY_EN
    sendBit((^d) ^ !parOk);
`endif
    sendBit(stopOk);
    sendBit(1'b1);
  endtask

  task automatic expectEvents(input string tag, input bit eByte, input logic [7:0] bVal,
                              input bit eWord, input logic [31:0] wA, input logic [31:0] wB,
                              input int eFerr, input int eTo, input int ePerr);
    @(posedge clk);
    #1;
    check({tag, " byte_ready count"}, 64'(byteQ.size()), 64'(eByte));
    if (eByte && byteQ.size() != 0) check({tag, " byte value"}, 64'(byteQ[0]), 64'(bVal));
    check({tag, " word_ready count lsb"}, 64'(wordQA.size()), 64'(eWord));
    if (eWord && wordQA.size() != 0) check({tag, " word lsb-first"}, 64'(wordQA[0]), 64'(wA));
    check({tag, " word_ready count msb"}, 64'(wordQB.size()), 64'(eWord));
    if (eWord && wordQB.size() != 0) check({tag, " word msb-first"}, 64'(wordQB[0]), 64'(wB));
    check({tag, " frame_error count"}, 64'(ferrA), 64'(eFerr));
    check({tag, " word_timeout count lsb"}, 64'(toA), 64'(eTo));
    check({tag, " word_timeout count msb"}, 64'(toB), 64'(eTo));
    check({tag, " parity_error count"}, 64'(perrA), 64'(ePerr));
    byteQ.delete();
    wordQA.delete();
    wordQB.delete();
    ferrA = 0;
    toA   = 0;
    toB   = 0;
    perrA = 0;
  endtask

  task automatic checkZeroOutputs(input string tag);
    check({tag, " byte_data"}, 64'(busA.RxD_byte_data), 64'h0);
    check({tag, " byte_ready"}, 64'(busA.RxD_byte_ready), 64'h0);
    check({tag, " word_data lsb"}, 64'(busA.RxD_word_data), 64'h0);
    check({tag, " word_data msb"}, 64'(busB.RxD_word_data), 64'h0);
    check({tag, " word_ready"}, 64'(busA.RxD_word_data_ready), 64'h0);
    check({tag, " frame_error"}, 64'(busA.frame_error), 64'h0);
    check({tag, " word_timeout"}, 64'(busA.word_timeout), 64'h0);
`ifdef UART_RX_PARITY_EN
    check({tag, " parity_error"}, 64'(busA.parity_error), 64'h0);
`endif
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          stopOk;
    bit          eByte;
    bit          eWord;
    logic [31:0] wA;
    logic [31:0] wB;
    bit          eFerr;
  } vecT;

  vecT vecs[10];

  initial begin
    logic [7:0]  d;
    logic [7:0]  partial[$];
    bit          stopOk, parOk, eByte, eWord;
    int          eF, eP, eT, r;
    logic [31:0] wA, wB;
    int          tStart, target;

    vecs[0] = '{8'h78, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{8'h56, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[2] = '{8'h34, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'h78563412, 1'b0};
    vecs[4] = '{8'h11, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{8'h22, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    vecs[6] = '{8'h33, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[7] = '{8'h44, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[8] = '{8'h55, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[9] = '{8'h66, 1'b1, 1'b1, 1'b1, 32'h66554433, 32'h33445566, 1'b0};

    repeat (3) @(negedge clk);
    checkZeroOutputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      sendFrame(vecs[i].data, vecs[i].stopOk, 1'b1);
      expectEvents($sformatf("vec%0d", i), vecs[i].eByte, vecs[i].data, vecs[i].eWord,
                   vecs[i].wA, vecs[i].wB, int'(vecs[i].eFerr), 0, 0);
    end

    // Short low glitch is a false start
    rxLine = 1'b0;
    repeat (10) @(negedge clk);
    rxLine = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    expectEvents("glitch", 1'b0, 8'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'hA5, 1'b1, 1'b1);
    expectEvents("after glitch", 1'b1, 8'hA5, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    repeat (20 * CPB) @(negedge clk);
    expectEvents("A5 timeout", 1'b0, 8'h0, 1'b0, 32'h0, 32'h0, 0, 1, 0);

    // Idle timeout whose expiry coincides with the next start edge
    sendFrame(8'hAA, 1'b1, 1'b1);
    expectEvents("AA", 1'b1, 8'hAA, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'hBB, 1'b1, 1'b1);
    expectEvents("BB", 1'b1, 8'hBB, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    tStart = byteCyc;
    target = tStart + int'(TO_CYCLES) - 3;
    while (cyc < target) @(negedge clk);
    check("start edge alignment", 64'(cyc), 64'(target));
    sendFrame(8'h01, 1'b1, 1'b1);
    check("timeout latency", 64'(toCycA - tStart), 64'(TO_CYCLES));
    expectEvents("01 after timeout", 1'b1, 8'h01, 1'b0, 32'h0, 32'h0, 0, 1, 0);
    sendFrame(8'h02, 1'b1, 1'b1);
    expectEvents("02", 1'b1, 8'h02, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'h03, 1'b1, 1'b1);
    expectEvents("03", 1'b1, 8'h03, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'h04, 1'b1, 1'b1);
    expectEvents("04", 1'b1, 8'h04, 1'b1, 32'h04030201, 32'h01020304, 0, 0, 0);

    // Reset during data bit 3
    d = 8'h5A;
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(d[i]);
    rxLine = d[3];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkZeroOutputs("mid-frame reset");
    rxLine = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    expectEvents("after reset", 1'b0, 8'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'hDE, 1'b1, 1'b1);
    expectEvents("DE", 1'b1, 8'hDE, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'hAD, 1'b1, 1'b1);
    expectEvents("AD", 1'b1, 8'hAD, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'hBE, 1'b1, 1'b1);
    expectEvents("BE", 1'b1, 8'hBE, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    sendFrame(8'hEF, 1'b1, 1'b1);
    expectEvents("EF", 1'b1, 8'hEF, 1'b1, 32'hEFBEADDE, 32'hDEADBEEF, 0, 0, 0);

    // Line stuck low: one framing error only
    rxLine = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    expectEvents("held low", 1'b0, 8'h0, 1'b0, 32'h0, 32'h0, 1, 0, 0);
    rxLine = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    expectEvents("released", 1'b0, 8'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0);

`ifdef UART_RX_PARITY_EN
    sendFrame(8'h07, 1'b1, 1'b0);
    expectEvents("parity 07", 1'b0, 8'h0, 1'b0, 32'h0, 32'h0, 0, 0, 1);
`endif

    // Random frames against a frame-level model
    partial.delete();
    for (int f = 0; f < 32; f++) begin
      d      = 8'($urandom);
      r      = int'($urandom_range(0, 9));
      stopOk = (r != 0);
      parOk  = 1'b1;
`ifdef UART_RX_PARITY_EN
      parOk  = (r != 1);
`endif
      eByte = 1'b0; eWord = 1'b0; eF = 0; eP = 0; eT = 0; wA = '0; wB = '0;
      sendFrame(d, stopOk, parOk);
      if (!stopOk) begin
        eF = 1;
        partial.delete();
      end else if (!parOk) begin
        eP = 1;
        partial.delete();
      end else begin
        eByte = 1'b1;
        partial.push_back(d);
        if (partial.size() == WB) begin
          eWord = 1'b1;
          for (int i = 0; i < int'(WB); i++) begin
            wA = wA | (32'(partial[i]) << (8 * i));
            wB = wB | (32'(partial[i]) << (8 * (int'(WB) - 1 - i)));
          end
          partial.delete();
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat (20 * CPB) @(negedge clk);
        if (partial.size() != 0) begin
          eT = 1;
          partial.delete();
        end
      end else begin
        repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
      end
      expectEvents($sformatf("rand%0d", f), eByte, d, eWord, wA, wB, eF, eT, eP);
    end

    check("word changes without strobe", 64'(stray), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
